cordic_lcd_sched: RTL

//  Top-level sequencer for the CORDIC sin/cos display path. Per update it issues
//  the phase, starts the CORDIC core, then the binary-to-decimal converter, then

---
 rtl/cordic_lcd_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cordic_lcd_sched.sv
// cordic_lcd_sched: sequences one display update (CORDIC -> BCD -> LCD refresh)
// per timer tick or step request, with a watchdog on every waiting stage.
module cordic_lcd_sched #(
  parameter int unsigned        ANGLE_W        = 32,
  parameter logic [ANGLE_W-1:0] ANGLE_STEP     = ANGLE_W'(32'h0100_0000),
  parameter int unsigned        REFRESH_CYCLES = 50_000_000,
  parameter int unsigned        TIMEOUT_CYCLES = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic               step_i,
  output logic [ANGLE_W-1:0] angle_o,
  output logic               cordic_start_o,
  input  logic               cordic_done_i,
  output logic               bcd_start_o,
  input  logic               bcd_done_i,
  input  logic               lcd_req_i,
  output logic               lcd_w_en_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int TMR_W = $clog2(REFRESH_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CORDIC_GO,
    S_CORDIC_WAIT,
    S_BCD_GO,
    S_BCD_WAIT,
    S_LCD_IDLE,
    S_LCD_GO,
    S_LCD_ACK,
    S_LCD_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [TMR_W-1:0]   r_timer;
  logic [TO_W-1:0]    r_tout;
  logic [ANGLE_W-1:0] r_angle;
  logic               r_pend;
  logic               r_err;
  logic               w_timer_hit;
  logic               w_req;
  logic               w_consume;
  logic               w_wait_state;
  logic               w_timeout;

  assign w_timer_hit = run_i && (r_timer == TMR_LAST);
  // A step and a timer tick in the same cycle collapse into one request.
  assign w_req       = step_i || w_timer_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_wait_state   = 1'b0;
    w_consume      = 1'b0;
    cordic_start_o = 1'b0;
    bcd_start_o    = 1'b0;
    lcd_w_en_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_consume    = 1'b1;
          w_state_next = S_CORDIC_GO;
        end
      end
      S_CORDIC_GO: begin
        cordic_start_o = 1'b1;
        w_state_next   = S_CORDIC_WAIT;
      end
      S_CORDIC_WAIT: begin
        w_wait_state = 1'b1;
        if (cordic_done_i) w_state_next = S_BCD_GO;
      end
      S_BCD_GO: begin
        bcd_start_o  = 1'b1;
        w_state_next = S_BCD_WAIT;
      end
      S_BCD_WAIT: begin
        w_wait_state = 1'b1;
        if (bcd_done_i) w_state_next = S_LCD_IDLE;
      end
      S_LCD_IDLE: begin
        w_wait_state = 1'b1;
        if (lcd_req_i) w_state_next = S_LCD_GO;
      end
      S_LCD_GO: begin
        lcd_w_en_o   = 1'b1;
        w_state_next = S_LCD_ACK;
      end
      S_LCD_ACK: begin
        w_wait_state = 1'b1;
        if (!lcd_req_i) w_state_next = S_LCD_BUSY;
      end
      S_LCD_BUSY: begin
        w_wait_state = 1'b1;
        if (lcd_req_i) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Progress on the final allowed cycle still wins over the watchdog.
    w_timeout = w_wait_state && (w_state_next == r_state) && (r_tout == TO_LAST);
    if (w_timeout) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_pend  <= 1'b0;
      r_tout  <= '0;
      r_angle <= '0;
      r_err   <= 1'b0;
    end else begin
      if (!run_i || w_timer_hit) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TMR_W'(1);
      end

      // A new request in the consuming cycle is kept as the next queued update.
      if (w_req) begin
        r_pend <= 1'b1;
      end else if (w_consume) begin
        r_pend <= 1'b0;
      end

      if (w_state_next != r_state) begin
        r_tout <= '0;
      end else if (w_wait_state) begin
        r_tout <= r_tout + TO_W'(1);
      end

      if (r_state == S_DONE) begin
        r_angle <= r_angle + ANGLE_STEP;
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign angle_o = r_angle;
  assign busy_o  = (r_state != S_IDLE);
  assign err_o   = r_err;

endmodule
